// File: rtl/conv_window_accumulator.sv
// Accumulates KERNEL_N signed products plus a channel bias, shifts, saturates to int8.
// Define CONV_ACC_RELU_EN to clamp negative results to zero before saturation.
module conv_window_accumulator #(
    parameter int KERNEL_N = 25,
    parameter int ACC_W    = 16,
    parameter int SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [7:0] prod_in,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic signed [7:0] bias,
    output logic signed [7:0] res_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              sat_flag
);
    typedef enum logic {ACC, DONE} state_t;

    localparam logic [7:0]              LAST    = 8'(KERNEL_N - 1);
    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(127);
`ifndef CONV_ACC_RELU_EN
    localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-128);
`endif

    state_t                  state;
    logic [7:0]              cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic signed [7:0]       res_next;
    logic                    sat_next;
    logic                    xfer;

    assign xfer = prod_valid && prod_ready;

    // The first product of a window starts from the freshly sampled bias instead of acc.
    // NOTE: every signal written in this block is assigned on every path, so no latch is inferred.
    always_comb begin
        base     = (cnt == 8'd0) ? ACC_W'(bias) : acc;
        sum      = base + ACC_W'(prod_in);
        shifted  = sum >>> SHIFT;
        res_next = shifted[7:0];
        sat_next = 1'b0;
        if (shifted > POS_LIM) begin
            res_next = 8'sd127;
            sat_next = 1'b1;
        end
`ifdef CONV_ACC_RELU_EN
        else if (shifted[ACC_W-1]) begin
            res_next = 8'sd0;
        end
`else
        else if (shifted < NEG_LIM) begin
            res_next = -8'sd128;
            sat_next = 1'b1;
        end
`endif
    end

    // NOTE: state is updated with non-blocking assignments; there is no memory array, so every register is reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC;
            cnt        <= 8'd0;
            acc        <= '0;
            res_out    <= 8'sd0;
            res_valid  <= 1'b0;
            sat_flag   <= 1'b0;
            prod_ready <= 1'b1;
        end else begin
            case (state)
                ACC: begin
                    if (xfer) begin
                        acc <= sum;
                        if (cnt == LAST) begin
                            cnt        <= 8'd0;
                            state      <= DONE;
                            res_out    <= res_next;
                            sat_flag   <= sat_next;
                            res_valid  <= 1'b1;
                            prod_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    // prod_ready follows state only, so res_ready never reaches it combinationally.
                    if (res_ready) begin
                        state      <= ACC;
                        res_valid  <= 1'b0;
                        prod_ready <= 1'b1;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule
